uart_cmd_xcvr: RTL and testbench
================================

// Module: uart_cmd_xcvr
// PURPOSE
// Full-duplex parametrised UART. Serialises a multi-byte command word onto tx under valid/ready handshake,
// and deserialises rx frames into bytes with parity and framing error flags. Sits between the host
// command/readback logic and the board UART pins. Successor to the fixed 8N1 command UART.
// PARAMETERS
// CLK_FREQ   50000000  system clock frequency, Hz
// BAUD       115200    line rate, bits/s; BAUD_DIV = (CLK_FREQ + BAUD/2) / BAUD clocks per bit
// DATA_BITS  8         data bits per frame, 5..9
// PARITY     0         0 none, 1 odd, 2 even
// STOP_BITS  1         stop bits transmitted, 1 or 2 (rx checks only the first)
// CMD_BYTES  2         bytes per command; CMD_W = CMD_BYTES*DATA_BITS
// PORTS
// clk         in   1          system clock, all logic on posedge
// rst_n       in   1          reset, asynchronous, active-low
// cmd_in      in   CMD_W      command word, sent least-significant byte first
// cmd_vld     in   1          command valid
// cmd_rdy     out  1          transmitter idle; accept when cmd_vld && cmd_rdy
// tx          out  1          serial out, idle high
// rx          in   1          serial in, asynchronous to clk
// rd_vld      out  1          one-cycle pulse: received frame available
// rd_data     out  DATA_BITS  received data, held until next rd_vld
// rd_par_err  out  1          parity mismatch for current rd_data; 0 when PARITY=0
// rd_frm_err  out  1          first stop bit sampled 0 for current rd_data
// BEHAVIOUR
// - Reset: tx=1, cmd_rdy=1, rd_vld=0, rd_data=0, rd_par_err=0, rd_frm_err=0. Both FSMs go to IDLE.
//   Asserting rst_n low mid-frame aborts the frame at once; the latched command is discarded.
// - Bit timer: per direction, counts 0..BAUD_DIV-1. Every tx bit lasts exactly BAUD_DIV clocks.
// - TX FSM: TX_IDLE -> TX_START -> TX_DATA (DATA_BITS, LSB first) -> [TX_PAR] -> TX_STOP (STOP_BITS)
//   -> next byte's TX_START, or TX_IDLE after byte CMD_BYTES-1.
// - TX handshake: on the accept edge, cmd_in is latched and the start bit is driven.
//   cmd_rdy falls in the cycle after accept. Bytes go back-to-back with no idle gap.
//   cmd_rdy rises in the cycle after the final stop bit completes. cmd_vld while busy is ignored.
// - Parity: odd means data^par has odd weight; even means even weight.
// - RX input: rx passes through a 2-flop synchroniser. The synchroniser resets to 1.
// - RX FSM: RX_IDLE -> RX_START -> RX_DATA -> [RX_PAR] -> RX_STOP -> RX_IDLE (or RX_BRK).
//   A 1->0 edge in RX_IDLE enters RX_START. Each bit is sampled at count BAUD_DIV/2.
//   A start-bit sample of 1 is a false start: return to RX_IDLE with no output.
// - RX output: at the stop-bit sample, the FSM updates rd_data/rd_par_err/rd_frm_err.
//   rd_vld is high exactly the next cycle, then the FSM re-arms in RX_IDLE.
//   Frames with errors are still delivered, with their flags set.
// - Break: if frm_err is set and data is all zero, the FSM enters RX_BRK.
//   It waits for rx=1 before re-arming, so a long low line yields exactly one rd_vld.
// - TX and RX are fully independent. Simultaneous accept and rd_vld need no arbitration.
// - Widths: timer width $clog2(BAUD_DIV); bit counter width $clog2(max(DATA_BITS,CMD_BYTES)+1).
// STRUCTURE
// - Package uart_pkg: PARITY_NONE/ODD/EVEN localparams, tx_state_t/rx_state_t enums, baud_div() function.
// - Sub-module uart_rx_frame: synchroniser, RX timer and FSM, error flags.
// - Top level holds the TX FSM, shift register and byte counter, and instantiates uart_rx_frame.
// TESTING (CLK_FREQ=1000000, BAUD=100000 -> BAUD_DIV=10; PARITY=2, STOP_BITS=1, CMD_BYTES=2 unless noted)
// 1. Reset, then idle 50 cycles -> tx=1, cmd_rdy=1, rd_vld never high, rd_* = 0.
// 2. cmd_in=16'hA55A, one-cycle vld -> tx sends 0x5A (even parity 0) then 0xA5 (parity 0).
//    Each bit is 10 clocks; cmd_rdy low for 220 cycles; a second vld mid-frame is ignored.
// 3. Loopback tx->rx with case 2 -> exactly two rd_vld pulses: 0x5A then 0xA5, both error flags 0.
// 4. Drive rx frame 0x3C with parity bit 1 -> rd_vld, rd_data=8'h3C, rd_par_err=1, rd_frm_err=0.
// 5. Frame 0x81 with stop=0 -> rd_frm_err=1.
//    rx low for 30 bit times -> one rd_vld (0x00, frm_err=1), no further pulses until rx high.
// 6. rx low 3 cycles then high -> no rd_vld.
//    rst_n low mid-byte of case 2 -> tx=1 and cmd_rdy=1 immediately; new command then sends cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised command UART.
// Provides parity mode encodings, TX/RX FSM state types and the baud divider helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP,
    RX_BRK
  } rx_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_cmd_xcvr_if.sv
// Host-side bus of the command UART.
// Command path: cmd_in/cmd_vld (host -> UART), cmd_rdy (UART -> host).
// Readback path: rd_vld/rd_data/rd_par_err/rd_frm_err (UART -> host).
// master = host logic, slave = uart_cmd_xcvr.
interface uart_cmd_xcvr_if #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned CMD_BYTES = 2
);
  localparam int unsigned CMD_W = CMD_BYTES * DATA_BITS;

  logic [CMD_W-1:0]     cmd_in;
  logic                 cmd_vld;
  logic                 cmd_rdy;
  logic                 rd_vld;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_par_err;
  logic                 rd_frm_err;

  modport master (
    output cmd_in, cmd_vld,
    input  cmd_rdy, rd_vld, rd_data, rd_par_err, rd_frm_err
  );

  modport slave (
    input  cmd_in, cmd_vld,
    output cmd_rdy, rd_vld, rd_data, rd_par_err, rd_frm_err
  );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receive framer: synchronises rx, samples each bit mid-period, checks
// parity and the first stop bit, and suppresses repeat output on a held break.
// Ports: clk, rst_n (async active-low), rx (async serial in),
//        rd_vld (1-cycle pulse), rd_data, rd_par_err, rd_frm_err (held until next rd_vld).
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = 434,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 rd_vld,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_par_err,
  output logic                 rd_frm_err
);

  localparam int unsigned TW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned BW   = $clog2(DATA_BITS + 1);
  localparam int unsigned HALF = BAUD_DIV / 2;
  localparam logic        PAR_ODD = 1'(PARITY == PARITY_ODD);
  localparam logic        PAR_EN  = 1'(PARITY != PARITY_NONE);

  rx_state_t            state_q, state_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_bit_q, par_bit_d;
  logic                 vld_q, vld_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;

  logic mid, tick, fall, last_data, brk;
  assign mid       = (cnt_q == TW'(HALF));
  assign tick      = (cnt_q == TW'(BAUD_DIV - 1));
  assign fall      = rx_prev_q & ~rx_s2_q;
  assign last_data = (bit_q == BW'(DATA_BITS - 1));
  assign brk       = ~rx_s2_q && (shreg_q == '0);

  // Two-flop synchroniser plus one delayed copy for edge detection; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      par_bit_q <= 1'b0;
      vld_q     <= 1'b0;
      data_q    <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      par_bit_q <= par_bit_d;
      vld_q     <= vld_d;
      data_q    <= data_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  // Next-state logic; the stop bit is left at its mid sample so a following start edge is not missed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (fall) state_d = RX_START;
      RX_START: begin
        if (mid && rx_s2_q) state_d = RX_IDLE;
        else if (tick)      state_d = RX_DATA;
      end
      RX_DATA:  if (tick && last_data) state_d = PAR_EN ? RX_PAR : RX_STOP;
      RX_PAR:   if (tick) state_d = RX_STOP;
      RX_STOP:  if (mid) state_d = brk ? RX_BRK : RX_IDLE;
      RX_BRK:   if (rx_s2_q) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  // Datapath and output logic.
  always_comb begin
    cnt_d     = tick ? '0 : cnt_q + TW'(1);
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_bit_d = par_bit_q;
    vld_d     = 1'b0;
    data_d    = data_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    case (state_q)
      RX_IDLE, RX_BRK: cnt_d = '0;
      RX_START: if (tick) bit_d = '0;
      RX_DATA: begin
        if (mid)  shreg_d = {rx_s2_q, shreg_q[DATA_BITS-1:1]};
        if (tick) bit_d = bit_q + BW'(1);
      end
      RX_PAR: if (mid) par_bit_d = rx_s2_q;
      RX_STOP: begin
        if (mid) begin
          vld_d     = 1'b1;
          data_d    = shreg_q;
          frm_err_d = ~rx_s2_q;
          par_err_d = PAR_EN && ((^shreg_q ^ par_bit_q) != PAR_ODD);
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign rd_vld     = vld_q;
  assign rd_data    = data_q;
  assign rd_par_err = par_err_q;
  assign rd_frm_err = frm_err_q;

endmodule

// File: rtl/uart_cmd_xcvr.sv
// Full-duplex parametrised command UART.
// Serialises a CMD_BYTES-byte command (LSB byte first) onto tx under valid/ready,
// and deserialises rx frames via uart_rx_frame.
// Ports: clk, rst_n (async active-low), bus (uart_cmd_xcvr_if.slave: cmd_in/cmd_vld/cmd_rdy,
//        rd_vld/rd_data/rd_par_err/rd_frm_err), tx (serial out, idle high), rx (serial in).
module uart_cmd_xcvr
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned CMD_BYTES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_cmd_xcvr_if.slave     bus,
  output logic               tx,
  input  logic               rx
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned TW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned CMD_W    = CMD_BYTES * DATA_BITS;
  localparam int unsigned BMAX     = (DATA_BITS > CMD_BYTES) ? DATA_BITS : CMD_BYTES;
  localparam int unsigned BW       = $clog2(BMAX + 1);
  localparam logic        PAR_ODD  = 1'(PARITY == PARITY_ODD);
  localparam logic        PAR_EN   = 1'(PARITY != PARITY_NONE);

  tx_state_t        state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [BW-1:0]    byte_q, byte_d;
  logic [CMD_W-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             rdy_q, rdy_d;

  logic accept, tick, last_data, last_stop, last_byte;
  assign accept    = bus.cmd_vld && rdy_q;
  assign tick      = (cnt_q == TW'(BAUD_DIV - 1));
  assign last_data = (bit_q == BW'(DATA_BITS - 1));
  assign last_stop = (bit_q == BW'(STOP_BITS - 1));
  assign last_byte = (byte_q == BW'(CMD_BYTES - 1));

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rdy_q   <= rdy_d;
    end
  end

  // Next-state logic; bytes chain STOP -> START with no idle gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:  if (accept) state_d = TX_START;
      TX_START: if (tick) state_d = TX_DATA;
      TX_DATA:  if (tick && last_data) state_d = PAR_EN ? TX_PAR : TX_STOP;
      TX_PAR:   if (tick) state_d = TX_STOP;
      TX_STOP:  if (tick && last_stop) state_d = last_byte ? TX_IDLE : TX_START;
      default:  state_d = TX_IDLE;
    endcase
  end

  // Datapath and outputs; tx is registered from the upcoming state so it changes on bit boundaries.
  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + TW'(1);
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    case (state_q)
      TX_IDLE: begin
        cnt_d  = '0;
        byte_d = '0;
        if (accept) shreg_d = bus.cmd_in;
      end
      TX_START: if (tick) bit_d = '0;
      TX_DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          bit_d   = last_data ? '0 : bit_q + BW'(1);
        end
      end
      TX_PAR: if (tick) bit_d = '0;
      TX_STOP: begin
        if (tick) begin
          bit_d = last_stop ? '0 : bit_q + BW'(1);
          if (last_stop) byte_d = byte_q + BW'(1);
        end
      end
      default: cnt_d = '0;
    endcase
    // Parity for the byte now at the bottom of the shift register, computed as its start bit begins.
    if (state_d == TX_START && state_q != TX_START)
      par_d = (^shreg_d[DATA_BITS-1:0]) ^ PAR_ODD;
    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shreg_d[0];
      TX_PAR:   tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    rdy_d = (state_d == TX_IDLE);
  end

  assign tx          = tx_q;
  assign bus.cmd_rdy = rdy_q;

  uart_rx_frame #(
    .BAUD_DIV  (BAUD_DIV),
    .DATA_BITS (DATA_BITS),
    .PARITY    (PARITY)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rd_vld     (bus.rd_vld),
    .rd_data    (bus.rd_data),
    .rd_par_err (bus.rd_par_err),
    .rd_frm_err (bus.rd_frm_err)
  );

endmodule

// File: tb/tb_uart_cmd_xcvr.sv
// Scoreboard bench for uart_cmd_xcvr: BAUD_DIV=10, even parity, 1 stop, 2-byte commands.
module tb_uart_cmd_xcvr;

  localparam int unsigned DB = 8;
  localparam int unsigned NB = 2;
  localparam int unsigned BD = 10;

  typedef struct { logic [7:0] d; logic p; } tx_exp_t;
  typedef struct { logic [7:0] d; logic pe; logic fe; } rx_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx, rx;
  logic rx_drv = 1'b1;
  logic loop = 1'b0;
  logic tx_mon_en = 1'b1;

  tx_exp_t tx_q[$];
  rx_exp_t rx_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign rx = loop ? tx : rx_drv;

  uart_cmd_xcvr_if #(.DATA_BITS(DB), .CMD_BYTES(NB)) bus ();

  uart_cmd_xcvr #(
    .CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(DB),
    .PARITY(2), .STOP_BITS(1), .CMD_BYTES(NB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .tx    (tx),
    .rx    (rx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // RX monitor: every rd_vld pulse must match the next expected frame.
  always @(negedge clk) begin : rx_mon
    rx_exp_t e;
    if (rst_n && bus.rd_vld) begin
      if (rx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got data %0h want no rd_vld", bus.rd_data);
      end else begin
        e = rx_q.pop_front();
        chk("rx_data", 32'(bus.rd_data), 32'(e.d));
        chk("rx_par_err", 32'(bus.rd_par_err), 32'(e.pe));
        chk("rx_frm_err", 32'(bus.rd_frm_err), 32'(e.fe));
      end
    end
  end

  // TX monitor: decodes the line at mid-bit and checks each frame against the scoreboard.
  initial begin : tx_mon
    tx_exp_t e;
    logic [7:0] d;
    logic p, s, st;
    forever begin
      @(negedge clk);
      if (rst_n && tx_mon_en && tx === 1'b0) begin
        repeat (BD / 2 - 1) @(negedge clk);
        st = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          d[i] = tx;
        end
        repeat (BD) @(negedge clk);
        p = tx;
        repeat (BD) @(negedge clk);
        s = tx;
        if (tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got byte %0h want no frame", d);
        end else begin
          e = tx_q.pop_front();
          chk("tx_start", 32'(st), 0);
          chk("tx_data", 32'(d), 32'(e.d));
          chk("tx_parity", 32'(p), 32'(e.p));
          chk("tx_stop", 32'(s), 1);
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    rx_drv = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (BD) @(negedge clk);
    end
    rx_drv = p;
    repeat (BD) @(negedge clk);
    rx_drv = s;
    repeat (BD) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * BD) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [15:0] c);
    bus.cmd_in  = c;
    bus.cmd_vld = 1'b1;
    @(negedge clk);
    bus.cmd_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((tx_q.size() != 0 || rx_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d tx / %0d rx pending want 0", tx_q.size(), rx_q.size());
    end
  endtask

  initial begin : main
    int n;
    bus.cmd_in  = '0;
    bus.cmd_vld = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    repeat (50) @(negedge clk);
    chk("idle_tx", 32'(tx), 1);
    chk("idle_cmd_rdy", 32'(bus.cmd_rdy), 1);
    chk("idle_rd_vld", 32'(bus.rd_vld), 0);
    chk("idle_rd_data", 32'(bus.rd_data), 0);
    chk("idle_par_err", 32'(bus.rd_par_err), 0);
    chk("idle_frm_err", 32'(bus.rd_frm_err), 0);

    // Two-byte command with loopback; a mid-frame vld must be ignored
    loop = 1'b1;
    tx_q.push_back('{8'h5A, 1'b0});
    tx_q.push_back('{8'hA5, 1'b0});
    rx_q.push_back('{8'h5A, 1'b0, 1'b0});
    rx_q.push_back('{8'hA5, 1'b0, 1'b0});
    send_cmd(16'hA55A);
    n = 0;
    while (bus.cmd_rdy == 1'b0 && n < 400) begin
      n++;
      if (n == 50) begin
        bus.cmd_in  = 16'h1234;
        bus.cmd_vld = 1'b1;
      end
      if (n == 51) bus.cmd_vld = 1'b0;
      @(negedge clk);
    end
    chk("cmd_rdy_low_cycles", 32'(n), 220);
    repeat (30) @(negedge clk);
    drain();
    loop = 1'b0;

    // Parity error frame
    rx_q.push_back('{8'h3C, 1'b1, 1'b0});
    send_frame(8'h3C, 1'b1, 1'b1);

    // Framing error frame
    rx_q.push_back('{8'h81, 1'b0, 1'b1});
    send_frame(8'h81, 1'b0, 1'b0);

    // Long break: exactly one delivery
    rx_q.push_back('{8'h00, 1'b0, 1'b1});
    rx_drv = 1'b0;
    repeat (30 * BD) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * BD) @(negedge clk);

    // Glitch shorter than half a bit: no delivery, previous data held
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (5 * BD) @(negedge clk);
    chk("hold_rd_data", 32'(bus.rd_data), 0);
    chk("hold_frm_err", 32'(bus.rd_frm_err), 1);
    drain();

    // Reset mid-byte aborts the transmission immediately
    tx_mon_en = 1'b0;
    send_cmd(16'hBEEF);
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_tx", 32'(tx), 1);
    chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 1);
    chk("rst_rd_data", 32'(bus.rd_data), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    tx_mon_en = 1'b1;

    // Clean command after reset, second byte with odd weight
    loop = 1'b1;
    tx_q.push_back('{8'h3C, 1'b0});
    tx_q.push_back('{8'h07, 1'b1});
    rx_q.push_back('{8'h3C, 1'b0, 1'b0});
    rx_q.push_back('{8'h07, 1'b0, 1'b0});
    send_cmd(16'h073C);
    repeat (260) @(negedge clk);
    chk("post_cmd_rdy", 32'(bus.cmd_rdy), 1);
    drain();
    repeat (50) @(negedge clk);
    chk("tx_queue_empty", 32'(tx_q.size()), 0);
    chk("rx_queue_empty", 32'(rx_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
